axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI-Lite initiator that turns a simple command/response interface into AXI-Lite write and read transactions.
- Drives our AXI-Lite peripherals (e.g. the UART TX slave) from test sequencers or small control FSMs, without hand-written bus sequencing.
- Includes a per-transaction watchdog that reports a stuck slave.

Parameters:
- ADDR_WIDTH, 4, width of command address and M_AXI_AWADDR/M_AXI_ARADDR.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, cycles allowed per transaction before abort; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- cmd_wstrb  in  DATA_WIDTH/8  write strobes (ignored for reads).
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP of the completed transaction.
- rsp_timeout  out  1  transaction aborted by the watchdog.
- M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY: AXI-Lite write channels. Widths follow the parameters; direction is master-side.
- M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: AXI-Lite read channels. Widths follow the parameters; direction is master-side.

Behaviour:
- Reset values: all *VALID, *READY and rsp_* outputs are 0. Address, data and strobe outputs are 0. State is IDLE.
- States:
  - IDLE: cmd_ready=1 (combinational decode of state, never in any other state). On cmd_valid&cmd_ready, latch the command, clear the watchdog, and go to WR or RD_ADDR.
  - WR: AWVALID and WVALID both rise together one cycle after acceptance. Each VALID drops the cycle after its own handshake (VALID&READY), tracked by aw_done/w_done flags. Both handshakes may occur in the same cycle or in either order. When both are done, go to WR_RESP.
  - WR_RESP: BREADY=1. On BVALID, capture BRESP, set rsp_rdata=0, drop BREADY, and go to RESP.
  - RD_ADDR: ARVALID=1 until ARREADY, then go to RD_DATA.
  - RD_DATA: RREADY=1. On RVALID, capture RDATA/RRESP and go to RESP.
  - RESP: rsp_valid=1 with stable rsp_* fields. On rsp_ready, go to IDLE.
- AXI rules:
  - VALIDs never depend combinationally on READYs.
  - Address, data and strobe stay stable while the corresponding VALID is high.
  - No new AW/AR is issued before the prior response completes.
- Minimum latency with an always-ready slave:
  - Write: acceptance at cycle 0, AW/W handshake at cycle 1, B at cycle 2 (slave registered), rsp_valid at cycle 3.
  - Read: rsp_valid at cycle 3 under the same conditions.
- Watchdog:
  - Counts every cycle spent in WR, WR_RESP, RD_ADDR or RD_DATA.
  - On reaching TIMEOUT_CYCLES: drop all VALID/READY outputs the same edge, go to RESP with rsp_timeout=1, rsp_resp=SLVERR (2'b10) and rsp_rdata=0.
  - This abort is a debug escape; a subsequent command toward the same slave has undefined outcome.
  - rsp_timeout=0 for normal completions.
- Simultaneous events: if BVALID/RVALID arrives on the same cycle the watchdog expires, the real response wins and rsp_timeout=0.
- Reset mid-transaction: all outputs return to reset values asynchronously and any in-flight command is lost.
- rsp_valid with rsp_ready low: hold indefinitely; cmd_ready stays 0.

Decomposition:
- Package axi_lite_pkg:
  - Response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - State enum IDLE/WR/WR_RESP/RD_ADDR/RD_DATA/RESP.
- Sub-module axi_lite_watchdog:
  - Ports: clear, enable, expired.
  - Counter width $clog2(TIMEOUT_CYCLES+1).
  - TIMEOUT_CYCLES=0 ties expired to 0.

Test Plan:
- Write addr 0x0, data 0x00000041, strb 0xF; slave gives AWREADY immediately, WREADY 3 cycles later -> AWVALID drops after 1 cycle, WVALID held 4 cycles; BRESP=00 gives rsp_valid with rsp_resp=00, rsp_rdata=0, rsp_timeout=0.
- Read addr 0x4; slave returns RDATA=0x00000001, RRESP=00 after 2 wait cycles -> rsp_rdata=0x00000001, rsp_resp=00, ARVALID stays stable until ARREADY.
- Read addr 0x8 returning 0xDEADBEEF with RRESP=10 -> rsp_rdata=0xDEADBEEF, rsp_resp=10 passed through unmodified.
- TIMEOUT_CYCLES=16, slave never asserts AWREADY -> exactly 16 cycles after WR entry, AWVALID=WVALID=0, rsp_valid=1, rsp_timeout=1, rsp_resp=10.
- Hold rsp_ready=0 for 10 cycles after a read completes -> rsp_* stable throughout, cmd_ready=0, no AXI VALIDs asserted; rsp_ready=1 returns to IDLE the next cycle.
- Assert rst_n=0 while in WR_RESP -> BREADY and all VALIDs 0 immediately; after release, cmd_ready=1 and a fresh write completes normally.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI-Lite initiator: response codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/axi_lite_watchdog.sv
// Per-transaction cycle counter that flags a stuck slave.
// Latency: expired is combinational, high during the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; clear wins over enable, counting freezes once expired.
// Ports: clk, rst_n; clear (restart count), enable (count this cycle), expired.
module axi_lite_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYCLES == 0) begin : g_disabled
    assign expired = 1'b0;
  end else begin : g_enabled
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    // Count holds the number of enabled cycles already completed, so the
    // final allowed cycle is the one where the count equals TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = enable && (cnt_q == LAST);

    always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
        cnt_d = '0;
      end else if (enable && !expired) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite initiator: command/response port to AXI-Lite write/read.
// Latency: command accepted in cycle 0 -> rsp_valid in cycle 3 with an always-ready slave.
// Backpressure: cmd_ready only in IDLE; rsp_valid held until rsp_ready; watchdog aborts stuck slaves.
// Ports: cmd_* (request in), rsp_* (completion out), M_AXI_* (AXI-Lite master channels).
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // command
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  // response
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  // AXI-Lite write
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  // AXI-Lite read
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  state_e                  state_q, state_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic                    timeout_q, timeout_d;

  logic wd_clear, wd_busy, wd_expired, abort;
  logic aw_fire, w_fire;

  // All handshake outputs are pure decodes of registered state, so no VALID
  // ever depends combinationally on a READY.
  assign cmd_ready     = (state_q == IDLE);
  assign M_AXI_AWVALID = (state_q == WR) && !aw_done_q;
  assign M_AXI_WVALID  = (state_q == WR) && !w_done_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARVALID = (state_q == RD_ADDR);
  assign M_AXI_RREADY  = (state_q == RD_DATA);

  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;

  assign rsp_valid     = (state_q == RESP);
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign rsp_timeout   = timeout_q;

  assign aw_fire = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_fire  = M_AXI_WVALID && M_AXI_WREADY;
  assign wd_busy = (state_q == WR) || (state_q == WR_RESP) ||
                   (state_q == RD_ADDR) || (state_q == RD_DATA);

  axi_lite_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_busy),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    wd_clear  = 1'b0;
    abort     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          timeout_d = 1'b0;
          wd_clear  = 1'b1;
          if (cmd_write) begin
            wdata_d = cmd_wdata;
            wstrb_d = cmd_wstrb;
            state_d = WR;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      WR: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if (wd_expired) begin
          abort = 1'b1;
        end else if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        // A real response on the expiry cycle takes priority over the abort.
        if (M_AXI_BVALID) begin
          resp_d    = M_AXI_BRESP;
          rdata_d   = '0;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        if (wd_expired) begin
          abort = 1'b1;
        end else if (M_AXI_ARREADY) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          resp_d    = M_AXI_RRESP;
          rdata_d   = M_AXI_RDATA;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (wd_expired) begin
          abort = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d   = RESP;
      resp_d    = RESP_SLVERR;
      rdata_d   = '0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= RESP_OKAY;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master with a hand-driven slave.
// Latency: checks cycle-exact handshake and response timing.
// Backpressure: exercises slow AW/W/AR/R slaves, held responses and watchdog aborts.
module tb_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .ADDR_WIDTH     (4),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .rsp_timeout   (rsp_timeout),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready),
    .M_AXI_ARADDR  (araddr),
    .M_AXI_ARVALID (arvalid),
    .M_AXI_ARREADY (arready),
    .M_AXI_RDATA   (rdata),
    .M_AXI_RRESP   (rresp),
    .M_AXI_RVALID  (rvalid),
    .M_AXI_RREADY  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge of the current cycle (output sample point).
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_no_axi(input string tag);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"},  wvalid,  0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_bready"},  bready,  0);
    chk({tag, "_rready"},  rready,  0);
  endtask

  // Consume the pending response and confirm the return to IDLE.
  task automatic drain(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    sample();
    chk({tag, "_idle_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_idle_cmd_ready"}, cmd_ready, 1);
    tick();
  endtask

  // Issue a read; slave waits ar_wait cycles before ARREADY and r_wait
  // cycles with RREADY high before RVALID. Ends one cycle into RESP.
  task automatic axi_read(input string tag, input logic [3:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input int ar_wait, input int r_wait);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = addr;
    sample();
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < ar_wait; i++) begin
      sample();
      chk({tag, "_arvalid_wait"}, arvalid, 1);
      chk({tag, "_araddr_wait"},  araddr,  addr);
      tick();
    end
    arready = 1'b1;
    sample();
    chk({tag, "_arvalid"}, arvalid, 1);
    chk({tag, "_araddr"},  araddr,  addr);
    tick();
    arready = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      sample();
      chk({tag, "_rready_wait"}, rready, 1);
      chk({tag, "_arvalid_off"}, arvalid, 0);
      tick();
    end
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    sample();
    chk({tag, "_rready"}, rready, 1);
    chk({tag, "_early_rsp"}, rsp_valid, 0);
    tick();
    rvalid = 1'b0;
    rdata  = 32'h0;
    rresp  = 2'b00;
    sample();
    chk({tag, "_rsp_valid"},   rsp_valid,   1);
    chk({tag, "_rsp_rdata"},   rsp_rdata,   data);
    chk({tag, "_rsp_resp"},    rsp_resp,    resp);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 0);
    chk({tag, "_rready_off"},  rready,      0);
    tick();
  endtask

  initial begin
    int aw_n;
    int w_n;
    rst_n = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;

    // Reset state
    repeat (2) tick();
    sample();
    chk_no_axi("rst");
    chk("rst_rsp_valid",   rsp_valid,   0);
    chk("rst_rsp_rdata",   rsp_rdata,   0);
    chk("rst_rsp_resp",    rsp_resp,    0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_awaddr",      awaddr,      0);
    chk("rst_wdata",       wdata,       0);
    chk("rst_wstrb",       wstrb,       0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write 0x41 to 0x0: AWREADY at once, WREADY three cycles later
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0;
    cmd_wdata = 32'h0000_0041; cmd_wstrb = 4'hF;
    sample();
    chk("w1_cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    aw_n = 0;
    w_n  = 0;
    for (int c = 1; c <= 4; c++) begin
      awready = (c == 1);
      wready  = (c == 4);
      sample();
      if (c == 1) begin
        chk("w1_awvalid_rise", awvalid, 1);
        chk("w1_wvalid_rise",  wvalid,  1);
      end
      if (awvalid) aw_n++;
      if (wvalid) begin
        w_n++;
        chk("w1_wdata", wdata, 32'h0000_0041);
        chk("w1_wstrb", wstrb, 4'hF);
      end
      chk("w1_cmd_ready_busy", cmd_ready, 0);
      tick();
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;
    bresp   = 2'b00;
    sample();
    chk("w1_aw_cycles", aw_n,   1);
    chk("w1_w_cycles",  w_n,    4);
    chk("w1_bready",    bready, 1);
    chk("w1_wvalid_off", wvalid, 0);
    tick();
    bvalid = 1'b0;
    sample();
    chk("w1_rsp_valid",   rsp_valid,   1);
    chk("w1_rsp_resp",    rsp_resp,    2'b00);
    chk("w1_rsp_rdata",   rsp_rdata,   0);
    chk("w1_rsp_timeout", rsp_timeout, 0);
    chk("w1_bready_off",  bready,      0);
    tick();
    drain("w1");

    // Read 0x4 with slow AR and R, then hold the response for 10 cycles
    axi_read("r1", 4'h4, 32'h0000_0001, 2'b00, 2, 2);
    for (int i = 0; i < 10; i++) begin
      sample();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h0000_0001);
      chk("hold_rsp_resp",  rsp_resp,  2'b00);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk_no_axi("hold");
      tick();
    end
    drain("r1");

    // Read 0x8, always-ready slave, SLVERR passes through; rsp_valid in cycle 3
    axi_read("r2", 4'h8, 32'hDEAD_BEEF, 2'b10, 0, 0);
    drain("r2");

    // Watchdog: AWREADY/WREADY never asserted
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'hC;
    cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'h3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sample();
      chk("to_awvalid_held", awvalid,   1);
      chk("to_wvalid_held",  wvalid,    1);
      chk("to_no_rsp",       rsp_valid, 0);
      tick();
    end
    sample();
    chk("to_awvalid_off", awvalid,     0);
    chk("to_wvalid_off",  wvalid,      0);
    chk("to_rsp_valid",   rsp_valid,   1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_resp",    rsp_resp,    2'b10);
    chk("to_rsp_rdata",   rsp_rdata,   0);
    tick();
    drain("to");

    // Reset while waiting in WR_RESP
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h2;
    cmd_wdata = 32'hA5A5_A5A5; cmd_wstrb = 4'h1;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    sample();
    chk("mr_bready_before", bready, 1);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk_no_axi("mr");
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_awaddr",    awaddr,    0);
    tick();
    rst_n = 1'b1;
    sample();
    chk("mr_cmd_ready", cmd_ready, 1);
    tick();

    // Fresh write after reset, always-ready slave with registered B
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h6;
    cmd_wdata = 32'h0000_00FF; cmd_wstrb = 4'h1;
    tick();
    cmd_valid = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    sample();
    chk("w2_awvalid", awvalid, 1);
    chk("w2_wvalid",  wvalid,  1);
    chk("w2_awaddr",  awaddr,  4'h6);
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b1;
    bresp   = 2'b01;
    sample();
    chk("w2_bready",    bready,    1);
    chk("w2_early_rsp", rsp_valid, 0);
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    sample();
    chk("w2_rsp_valid",   rsp_valid,   1);
    chk("w2_rsp_resp",    rsp_resp,    2'b01);
    chk("w2_rsp_rdata",   rsp_rdata,   0);
    chk("w2_rsp_timeout", rsp_timeout, 0);
    tick();
    drain("w2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
